// File: rtl/harness_pkg.sv
// Shared state type, polynomials and signature helpers for the stimulus/signature harness.
package harness_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StApply,
        StCapture,
        StDone
    } state_e;

    localparam logic [63:0] LFSR_POLY  = 64'hD800_0000_0000_0000;
    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] SIG_INIT   = 32'hFFFF_FFFF;
    // Widest DUT output the fold accepts; narrower outputs are zero-extended.
    localparam int unsigned FOLD_MAX_W = 4096;

    function automatic logic [31:0] fold(input logic [FOLD_MAX_W-1:0] data);
        logic [31:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < FOLD_MAX_W / 32; i++) begin
            acc ^= data[i*32 +: 32];
        end
        return acc;
    endfunction

    function automatic logic [31:0] sig_step(input logic [31:0] cur, input logic [31:0] f);
        return {cur[30:0], 1'b0} ^ (cur[31] ? CRC_POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 64'h0);
    endfunction

endpackage

// File: rtl/sig_misr.sv
// Signature register: folds the DUT output into 32 bits and compresses it CRC-style.
module sig_misr #(
    parameter int OUT_W = 567
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic [OUT_W-1:0] dut_out,
    output logic [31:0]      sig
);
    import harness_pkg::*;

    if (OUT_W < 1 || OUT_W > int'(FOLD_MAX_W)) begin : g_bad_out_w
        $error("sig_misr: OUT_W out of range");
    end

    logic [FOLD_MAX_W-1:0] w_dut_wide;
    logic [31:0]           r_sig;

    always_comb begin
        w_dut_wide              = '0;
        w_dut_wide[OUT_W-1:0]   = dut_out;
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            r_sig <= SIG_INIT;
        end else if (en) begin
            r_sig <= sig_step(r_sig, fold(w_dut_wide));
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/stim_sig_harness.sv
// Pseudo-random stimulus generator and output signature checker for one fuzzed DUT,
// with an optional valid/ready trace of each captured output vector.
module stim_sig_harness #(
    parameter int          IN_W     = 53,
    parameter int          OUT_W    = 567,
    parameter int          N_VEC    = 21,
    parameter int          HOLD     = 1,
    parameter logic [63:0] SEED     = 64'h1,
    parameter bit          TRACE_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    input  logic [31:0]                exp_sig,
    output logic [31:0]                sig,
    output logic [IN_W-1:0]            stim,
    input  logic [OUT_W-1:0]           dut_out,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [OUT_W-1:0]           trace_data,
    output logic [$clog2(N_VEC+1)-1:0] trace_idx
);
    import harness_pkg::*;

    localparam int          IDX_W    = $clog2(N_VEC + 1);
    localparam int          HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;

    if (IN_W < 1 || IN_W > 64) begin : g_bad_in_w
        $error("stim_sig_harness: IN_W must be within 1..64");
    end
    if (N_VEC < 1) begin : g_bad_n_vec
        $error("stim_sig_harness: N_VEC must be at least 1");
    end
    if (HOLD < 1) begin : g_bad_hold
        $error("stim_sig_harness: HOLD must be at least 1");
    end

    state_e             r_state;
    state_e             w_state_next;
    logic [63:0]        r_lfsr;
    logic [63:0]        w_lfsr_next;
    logic [IN_W-1:0]    r_stim;
    logic [IDX_W-1:0]   r_vec;
    logic [HOLD_W-1:0]  r_hold;
    logic [OUT_W-1:0]   r_trace_data;
    logic               w_hold_last;
    logic               w_last_vec;
    logic               w_enter_capture;
    logic               w_capture_fire;
    logic               w_ready;

    assign w_lfsr_next     = lfsr_step(r_lfsr);
    assign w_hold_last     = (r_hold == HOLD_W'(HOLD - 1));
    assign w_last_vec      = (r_vec == IDX_W'(N_VEC - 1));
    assign w_ready         = TRACE_EN ? trace_ready : 1'b1;
    assign w_enter_capture = (r_state == StApply) && w_hold_last;
    assign w_capture_fire  = (r_state == StCapture) && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (start) w_state_next = StLoad;
            StLoad:    w_state_next = StApply;
            StApply:   if (w_hold_last) w_state_next = StCapture;
            StCapture: if (w_ready) w_state_next = w_last_vec ? StDone : StApply;
            StDone:    if (start) w_state_next = StLoad;
            default:   w_state_next = StIdle;
        endcase
    end

    // Output is sampled on entry to CAPTURE so trace_data is valid for the whole handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr       <= '0;
            r_stim       <= '0;
            r_vec        <= '0;
            r_hold       <= '0;
            r_trace_data <= '0;
        end else begin
            if (r_state == StLoad) begin
                r_lfsr <= SEED_EFF;
                r_stim <= SEED_EFF[IN_W-1:0];
                r_vec  <= '0;
                r_hold <= '0;
            end
            if (r_state == StApply) begin
                r_hold <= w_hold_last ? '0 : r_hold + 1'b1;
            end
            if (w_enter_capture) begin
                r_trace_data <= dut_out;
            end
            if (w_capture_fire) begin
                r_lfsr <= w_lfsr_next;
                r_vec  <= r_vec + 1'b1;
                if (!w_last_vec) begin
                    r_stim <= w_lfsr_next[IN_W-1:0];
                end
            end
        end
    end

    sig_misr #(
        .OUT_W (OUT_W)
    ) u_sig_misr (
        .clk     (clk),
        .rst     (rst),
        .init    (r_state == StLoad),
        .en      (w_enter_capture),
        .dut_out (dut_out),
        .sig     (sig)
    );

    assign busy        = (r_state == StLoad) || (r_state == StApply) || (r_state == StCapture);
    assign done        = (r_state == StDone);
    assign pass        = done && (sig == exp_sig);
    assign stim        = r_stim;
    assign trace_valid = TRACE_EN && (r_state == StCapture);
    assign trace_data  = r_trace_data;
    assign trace_idx   = r_vec;

endmodule
